// File: rtl/scroll_latch_bank.sv
// ---------------------------------------------------------------------------
// scroll_latch_bank
//
// Multi-layer, double-buffered scroll register bank for the tilemap path.
// The CPU writes into a shadow copy of each register. On every VBLANK
// falling edge the shadow scroll values of every non-frozen layer are copied
// into the active copy that drives the tilemap engine. A layer can also
// auto-step its shadow scroll by a signed per-frame delta.
//
// Per-layer register map (CA[5:3] = layer, CA[2:0] = register):
//   0  HSCROLL[7:0]
//   1  HSCROLL[HSCROLL_W-1:8]
//   2  VSCROLL[7:0]
//   3  VSCROLL[VSCROLL_W-1:8]   (reads 0 when VSCROLL_W = 8)
//   4  HSTEP (signed)
//   5  VSTEP (signed)
//   6  CTRL  bit0 H auto, bit1 V auto, bit2 FREEZE
//   7  reserved, reads 0
//
// Ports:
//   CLK_6M   pixel clock, the only clock
//   RST      synchronous active-high reset
//   LATCH    CPU strobe; its rising edge starts one access
//   CA       CPU address {layer, register}
//   CD       CPU write data
//   RnW      1 = read, 0 = write, sampled with the LATCH rising edge
//   nVBLANK  active-low vertical blank from the timing block
//   DOUT     read data from the shadow copy, valid 1 cycle after the strobe
//   HSCROLL  active horizontal scroll, layer n at [n*HSCROLL_W +: HSCROLL_W]
//   VSCROLL  active vertical scroll, layer n at [n*VSCROLL_W +: VSCROLL_W]
//   COMMIT   one-cycle pulse on the cycle the active copy updates
//   FRAME    number of commits since reset, wraps at 16 bits
//
// STEP_W is expected to be at most 8, since steps are loaded from CD.
// ---------------------------------------------------------------------------
module scroll_latch_bank #(
    parameter int LAYERS    = 4,
    parameter int HSCROLL_W = 9,
    parameter int VSCROLL_W = 8,
    parameter int STEP_W    = 8
) (
    input  logic                        CLK_6M,
    input  logic                        RST,
    input  logic                        LATCH,
    input  logic [5:0]                  CA,
    input  logic [7:0]                  CD,
    input  logic                        RnW,
    input  logic                        nVBLANK,
    output logic [7:0]                  DOUT,
    output logic [LAYERS*HSCROLL_W-1:0] HSCROLL,
    output logic [LAYERS*VSCROLL_W-1:0] VSCROLL,
    output logic                        COMMIT,
    output logic [15:0]                 FRAME
);

    // Masks selecting the low byte of each scroll field. Byte writes merge
    // through these so the same code works for every field width.
    localparam logic [HSCROLL_W-1:0] H_LO = HSCROLL_W'(8'hFF);
    localparam logic [VSCROLL_W-1:0] V_LO = VSCROLL_W'(8'hFF);

    localparam logic [2:0] REG_H_LO  = 3'd0;
    localparam logic [2:0] REG_H_HI  = 3'd1;
    localparam logic [2:0] REG_V_LO  = 3'd2;
    localparam logic [2:0] REG_V_HI  = 3'd3;
    localparam logic [2:0] REG_HSTEP = 3'd4;
    localparam logic [2:0] REG_VSTEP = 3'd5;
    localparam logic [2:0] REG_CTRL  = 3'd6;

    localparam int CTRL_H_AUTO = 0;
    localparam int CTRL_V_AUTO = 1;
    localparam int CTRL_FREEZE = 2;

    logic                 latch_q;
    logic                 nvblank_q;
    logic                 wr_ev;
    logic                 vb_ev;
    logic                 wr_en;
    logic                 rd_en;
    logic [2:0]           ca_layer;
    logic [2:0]           ca_reg;
    logic [7:0]           rd_data;

    logic [HSCROLL_W-1:0] sh_h       [LAYERS];
    logic [VSCROLL_W-1:0] sh_v       [LAYERS];
    logic [HSCROLL_W-1:0] act_h      [LAYERS];
    logic [VSCROLL_W-1:0] act_v      [LAYERS];
    logic [STEP_W-1:0]    step_h     [LAYERS];
    logic [STEP_W-1:0]    step_v     [LAYERS];
    logic [2:0]           ctrl       [LAYERS];

    logic [HSCROLL_W-1:0] sh_h_nxt   [LAYERS];
    logic [VSCROLL_W-1:0] sh_v_nxt   [LAYERS];
    logic [STEP_W-1:0]    step_h_nxt [LAYERS];
    logic [STEP_W-1:0]    step_v_nxt [LAYERS];
    logic [2:0]           ctrl_nxt   [LAYERS];
    logic                 commit_l   [LAYERS];

    assign ca_layer = CA[5:3];
    assign ca_reg   = CA[2:0];

    assign wr_ev = LATCH & ~latch_q;
    assign vb_ev = ~nVBLANK & nvblank_q;
    assign wr_en = wr_ev & ~RnW;
    assign rd_en = wr_ev & RnW;

    // Shadow next-state. The auto-step is applied first, then a same-cycle
    // CPU write replaces only the byte field it addresses, so the other
    // byte of the same scroll value keeps its stepped bits. Layer indices
    // at or above LAYERS never match the loop and are silently dropped.
    always_comb begin
        for (int l = 0; l < LAYERS; l++) begin
            sh_h_nxt[l]   = sh_h[l];
            sh_v_nxt[l]   = sh_v[l];
            step_h_nxt[l] = step_h[l];
            step_v_nxt[l] = step_v[l];
            ctrl_nxt[l]   = ctrl[l];
            commit_l[l]   = vb_ev & ~ctrl[l][CTRL_FREEZE];

            if (commit_l[l] && ctrl[l][CTRL_H_AUTO]) begin
                sh_h_nxt[l] = sh_h[l] + HSCROLL_W'($signed(step_h[l]));
            end
            if (commit_l[l] && ctrl[l][CTRL_V_AUTO]) begin
                sh_v_nxt[l] = sh_v[l] + VSCROLL_W'($signed(step_v[l]));
            end

            if (wr_en && (ca_layer == 3'(l))) begin
                case (ca_reg)
                    REG_H_LO:  sh_h_nxt[l] = (sh_h_nxt[l] & ~H_LO) | (HSCROLL_W'(CD) & H_LO);
                    REG_H_HI:  sh_h_nxt[l] = (sh_h_nxt[l] & H_LO) | (HSCROLL_W'({CD, 8'h00}) & ~H_LO);
                    REG_V_LO:  sh_v_nxt[l] = (sh_v_nxt[l] & ~V_LO) | (VSCROLL_W'(CD) & V_LO);
                    REG_V_HI:  sh_v_nxt[l] = (sh_v_nxt[l] & V_LO) | (VSCROLL_W'({CD, 8'h00}) & ~V_LO);
                    REG_HSTEP: step_h_nxt[l] = STEP_W'(CD);
                    REG_VSTEP: step_v_nxt[l] = STEP_W'(CD);
                    REG_CTRL:  ctrl_nxt[l] = CD[2:0];
                    default:   ;
                endcase
            end
        end
    end

    // Read mux over the shadow copy. Upper bytes are right-shifted so a
    // field narrower than 16 bits (or absent, for an 8-bit VSCROLL) reads
    // back zero-extended.
    always_comb begin
        rd_data = 8'h00;
        for (int l = 0; l < LAYERS; l++) begin
            if (ca_layer == 3'(l)) begin
                case (ca_reg)
                    REG_H_LO:  rd_data = 8'(sh_h[l]);
                    REG_H_HI:  rd_data = 8'(sh_h[l] >> 8);
                    REG_V_LO:  rd_data = 8'(sh_v[l]);
                    REG_V_HI:  rd_data = 8'(sh_v[l] >> 8);
                    REG_HSTEP: rd_data = 8'(step_h[l]);
                    REG_VSTEP: rd_data = 8'(step_v[l]);
                    REG_CTRL:  rd_data = {5'b00000, ctrl[l]};
                    default:   rd_data = 8'h00;
                endcase
            end
        end
    end

    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            // nvblank_q resets high so releasing reset outside VBLANK
            // cannot look like a falling edge.
            latch_q   <= 1'b0;
            nvblank_q <= 1'b1;
            DOUT      <= 8'h00;
            COMMIT    <= 1'b0;
            FRAME     <= 16'h0000;
            for (int l = 0; l < LAYERS; l++) begin
                sh_h[l]   <= '0;
                sh_v[l]   <= '0;
                act_h[l]  <= '0;
                act_v[l]  <= '0;
                step_h[l] <= '0;
                step_v[l] <= '0;
                ctrl[l]   <= '0;
            end
        end else begin
            latch_q   <= LATCH;
            nvblank_q <= nVBLANK;
            COMMIT    <= vb_ev;
            if (vb_ev) begin
                FRAME <= FRAME + 16'd1;
            end
            if (rd_en) begin
                DOUT <= rd_data;
            end
            for (int l = 0; l < LAYERS; l++) begin
                sh_h[l]   <= sh_h_nxt[l];
                sh_v[l]   <= sh_v_nxt[l];
                step_h[l] <= step_h_nxt[l];
                step_v[l] <= step_v_nxt[l];
                ctrl[l]   <= ctrl_nxt[l];
                // Active takes the shadow as it stood before this cycle's
                // write or auto-step.
                if (commit_l[l]) begin
                    act_h[l] <= sh_h[l];
                    act_v[l] <= sh_v[l];
                end
            end
        end
    end

    for (genvar g = 0; g < LAYERS; g++) begin : g_pack
        assign HSCROLL[g*HSCROLL_W +: HSCROLL_W] = act_h[g];
        assign VSCROLL[g*VSCROLL_W +: VSCROLL_W] = act_v[g];
    end

endmodule

// File: tb/tb_scroll_latch_bank.sv
// ---------------------------------------------------------------------------
// tb_scroll_latch_bank
//
// Bench for scroll_latch_bank with LAYERS=4, HSCROLL_W=9, VSCROLL_W=8,
// STEP_W=8. Expected commit snapshots and read data are queued when the
// stimulus is driven and compared when the DUT responds.
// ---------------------------------------------------------------------------
module tb_scroll_latch_bank;

    logic        clk;
    logic        RST;
    logic        LATCH;
    logic [5:0]  CA;
    logic [7:0]  CD;
    logic        RnW;
    logic        nVBLANK;
    logic [7:0]  DOUT;
    logic [35:0] HSCROLL;
    logic [31:0] VSCROLL;
    logic        COMMIT;
    logic [15:0] FRAME;

    typedef struct packed {
        logic [35:0] h;
        logic [31:0] v;
        logic [15:0] f;
    } commit_t;

    commit_t     exp_q [$];
    logic [7:0]  rd_q  [$];
    commit_t     mon_e;
    logic        commit_prev;
    int          n_checks;
    int          n_fail;
    logic [15:0] frame_cnt;

    scroll_latch_bank #(
        .LAYERS   (4),
        .HSCROLL_W(9),
        .VSCROLL_W(8),
        .STEP_W   (8)
    ) dut (
        .CLK_6M (clk),
        .RST    (RST),
        .LATCH  (LATCH),
        .CA     (CA),
        .CD     (CD),
        .RnW    (RnW),
        .nVBLANK(nVBLANK),
        .DOUT   (DOUT),
        .HSCROLL(HSCROLL),
        .VSCROLL(VSCROLL),
        .COMMIT (COMMIT),
        .FRAME  (FRAME)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] ph(input logic [8:0] a0, input logic [8:0] a1,
                                       input logic [8:0] a2, input logic [8:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [31:0] pv(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2, input logic [7:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] layer, input logic [2:0] r, input logic [7:0] d);
        CA    = {layer, r};
        CD    = d;
        RnW   = 1'b0;
        LATCH = 1'b1;
        tick();
        LATCH = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [2:0] layer, input logic [2:0] r, input logic [7:0] exp,
                      input string tag);
        logic [7:0] e;
        rd_q.push_back(exp);
        CA    = {layer, r};
        CD    = 8'h00;
        RnW   = 1'b1;
        LATCH = 1'b1;
        tick();
        e = rd_q.pop_front();
        check(tag, 64'(DOUT), 64'(e));
        LATCH = 1'b0;
        RnW   = 1'b0;
        tick();
    endtask

    // One VBLANK falling edge, optionally with a CPU write on the same edge.
    task automatic frame(input logic [35:0] h, input logic [31:0] v,
                         input bit sim_wr, input logic [5:0] a, input logic [7:0] d);
        frame_cnt = frame_cnt + 16'd1;
        exp_q.push_back('{h: h, v: v, f: frame_cnt});
        nVBLANK = 1'b0;
        if (sim_wr) begin
            CA    = a;
            CD    = d;
            RnW   = 1'b0;
            LATCH = 1'b1;
        end
        tick();
        LATCH = 1'b0;
        tick();
        nVBLANK = 1'b1;
        tick();
        tick();
        check("commit_seen", 64'(exp_q.size()), 64'h0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (COMMIT === 1'b1) begin
            check("commit_width", 64'(commit_prev), 64'h0);
            check("commit_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("hscroll", 64'(HSCROLL), 64'(mon_e.h));
                check("vscroll", 64'(VSCROLL), 64'(mon_e.v));
                check("frame", 64'(FRAME), 64'(mon_e.f));
            end
        end
        commit_prev = COMMIT;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        frame_cnt   = 16'd0;
        commit_prev = 1'b0;
        RST         = 1'b1;
        LATCH       = 1'b0;
        CA          = 6'd0;
        CD          = 8'h00;
        RnW         = 1'b0;
        nVBLANK     = 1'b1;
        repeat (3) tick();
        check("rst_hscroll", 64'(HSCROLL), 64'h0);
        check("rst_vscroll", 64'(VSCROLL), 64'h0);
        check("rst_dout", 64'(DOUT), 64'h0);
        check("rst_commit", 64'(COMMIT), 64'h0);
        check("rst_frame", 64'(FRAME), 64'h0);
        RST = 1'b0;
        tick();

        // Shadow write is invisible until the commit.
        wr(3'd0, 3'd0, 8'h34);
        wr(3'd0, 3'd1, 8'h01);
        repeat (4) tick();
        check("t1_hold_h", 64'(HSCROLL), 64'h0);
        rd(3'd0, 3'd1, 8'h01, "t1_rd_hhi");
        rd(3'd0, 3'd0, 8'h34, "t1_rd_hlo");
        frame(ph(9'h134, 9'h0, 9'h0, 9'h0), pv(8'h0, 8'h0, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);

        // Layer 2 H auto-step +1 wrapping at 9 bits.
        wr(3'd2, 3'd4, 8'h01);
        wr(3'd2, 3'd6, 8'h01);
        wr(3'd2, 3'd0, 8'hFF);
        wr(3'd2, 3'd1, 8'h01);
        frame(ph(9'h134, 9'h0, 9'h1FF, 9'h0), pv(8'h0, 8'h0, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        frame(ph(9'h134, 9'h0, 9'h000, 9'h0), pv(8'h0, 8'h0, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        frame(ph(9'h134, 9'h0, 9'h001, 9'h0), pv(8'h0, 8'h0, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        wr(3'd2, 3'd6, 8'h00);
        rd(3'd2, 3'd0, 8'h02, "t2_rd_shadow_ahead");

        // Layer 1 V auto-step -2.
        wr(3'd1, 3'd5, 8'hFE);
        wr(3'd1, 3'd6, 8'h02);
        wr(3'd1, 3'd2, 8'h01);
        frame(ph(9'h134, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'h01, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        frame(ph(9'h134, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFF, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        wr(3'd1, 3'd6, 8'h00);

        // Write coinciding with the commit edge on layer 0.
        wr(3'd0, 3'd0, 8'h10);
        wr(3'd0, 3'd1, 8'h00);
        wr(3'd0, 3'd4, 8'h01);
        wr(3'd0, 3'd6, 8'h01);
        frame(ph(9'h010, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b1, 6'd0, 8'h55);
        frame(ph(9'h055, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        // Step carries into the high bits while the low byte is overwritten.
        wr(3'd0, 3'd0, 8'hFF);
        frame(ph(9'h0FF, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b1, 6'd0, 8'h55);
        frame(ph(9'h155, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        wr(3'd0, 3'd6, 8'h00);

        // FREEZE on layer 3; upper CTRL bits are dropped.
        wr(3'd3, 3'd6, 8'hFC);
        wr(3'd3, 3'd0, 8'hAA);
        wr(3'd3, 3'd1, 8'h00);
        rd(3'd3, 3'd6, 8'h04, "t5_rd_ctrl");
        wr(3'd2, 3'd7, 8'h5A);
        check("t5_dout_hold", 64'(DOUT), 64'h04);
        frame(ph(9'h156, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        frame(ph(9'h156, 9'h0, 9'h002, 9'h0), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        wr(3'd3, 3'd6, 8'h00);
        frame(ph(9'h156, 9'h0, 9'h002, 9'h0AA), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);

        // Out-of-range layer, reserved register, absent V high byte.
        wr(3'd5, 3'd0, 8'h77);
        rd(3'd5, 3'd0, 8'h00, "t6_rd_bad_layer");
        wr(3'd0, 3'd7, 8'h12);
        rd(3'd0, 3'd7, 8'h00, "t6_rd_reserved");
        rd(3'd1, 3'd3, 8'h00, "t6_rd_vhi");
        rd(3'd1, 3'd5, 8'hFE, "t6_rd_vstep");
        rd(3'd0, 3'd1, 8'h01, "t6_rd_hhi");
        frame(ph(9'h156, 9'h0, 9'h002, 9'h0AA), pv(8'h0, 8'hFD, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);

        // Reset mid-frame with a pending shadow write.
        wr(3'd3, 3'd0, 8'h11);
        RST = 1'b1;
        tick();
        tick();
        check("t6_rst_hscroll", 64'(HSCROLL), 64'h0);
        check("t6_rst_vscroll", 64'(VSCROLL), 64'h0);
        check("t6_rst_dout", 64'(DOUT), 64'h0);
        check("t6_rst_commit", 64'(COMMIT), 64'h0);
        check("t6_rst_frame", 64'(FRAME), 64'h0);
        RST       = 1'b0;
        frame_cnt = 16'd0;
        repeat (6) tick();
        check("t6_no_commit_frame", 64'(FRAME), 64'h0);
        frame(ph(9'h0, 9'h0, 9'h0, 9'h0), pv(8'h0, 8'h0, 8'h0, 8'h0), 1'b0, 6'd0, 8'h00);
        rd(3'd3, 3'd0, 8'h00, "t6_rd_discarded");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_latch_bank.md
Name: scroll_latch_bank

Overview:
- Parametrised, multi-layer scroll register bank for the tilemap subsystem.
- Generalises the single-layer CUS42 scroll latch: supports LAYERS tilemap layers, each with horizontal and vertical scroll.
- Every register is double-buffered: CPU writes land in a shadow copy, and shadow is committed to the active copy once per frame at VBLANK start.
- Optional per-layer auto-scroll adds a signed step each frame, so benches and attract modes can scroll without CPU traffic.

Parameters:
- LAYERS, 4: number of tilemap layers (1..8).
- HSCROLL_W, 9: horizontal scroll width in bits (9..12).
- VSCROLL_W, 8: vertical scroll width in bits (8..12).
- STEP_W, 8: signed auto-step width in bits.

Ports:
- CLK_6M  in  1  pixel clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- LATCH  in  1  CPU write strobe, active high, synchronous to CLK_6M, high for at least 1 cycle.
- CA  in  6  CPU address: CA[5:3] = layer, CA[2:0] = register.
- CD  in  8  CPU write data.
- RnW  in  1  1 = read, 0 = write; sampled on the LATCH rising edge.
- nVBLANK  in  1  from timing_subsystem, active low.
- DOUT  out  8  read data from the shadow register.
- HSCROLL  out  LAYERS*HSCROLL_W  active horizontal scroll; layer n occupies bits [n*HSCROLL_W +: HSCROLL_W].
- VSCROLL  out  LAYERS*VSCROLL_W  active vertical scroll, packed the same way.
- COMMIT  out  1  one-cycle pulse on the cycle the active copy updates.
- FRAME  out  16  count of commits.

Behaviour:
- Edge detection:
  - Registered copies of LATCH and nVBLANK.
  - wr_ev = LATCH & ~LATCH_q.
  - vb_ev = ~nVBLANK & nVBLANK_q (VBLANK falling edge).
- Register map per layer (CA[2:0]); all writes go to shadow:
  - 0: HSCROLL[7:0].
  - 1: HSCROLL[HSCROLL_W-1:8] from CD[HSCROLL_W-9:0]; other bits ignored.
  - 2: VSCROLL[7:0].
  - 3: VSCROLL[VSCROLL_W-1:8] (ignored when VSCROLL_W = 8).
  - 4: HSTEP (signed, STEP_W bits).
  - 5: VSTEP.
  - 6: CTRL. bit0 = H auto-enable, bit1 = V auto-enable, bit2 = FREEZE (suppress commit for this layer). bits 7:3 read as 0.
  - 7: reserved. Writes ignored, reads return 0x00.
- Layer range: a layer index >= LAYERS makes writes no-ops and reads return 0x00.
- Read:
  - On wr_ev with RnW = 1, DOUT is loaded on the next edge with the addressed shadow value, zero-extended.
  - DOUT holds until the next read. Latency is 1 cycle after wr_ev.
- Commit on vb_ev, for each layer whose FREEZE is 0:
  - active <= shadow (value before any same-cycle write).
  - If H auto-enable: shadow_H <= shadow_H + sign_extend(HSTEP), modulo 2^HSCROLL_W.
  - If V auto-enable: shadow_V <= shadow_V + sign_extend(VSTEP), modulo 2^VSCROLL_W.
  - Active therefore shows frame N's value while shadow already holds frame N+1's value.
- FREEZE:
  - A layer with FREEZE = 1 holds its active copy and does not auto-step.
  - Its CPU writes still update shadow.
- Simultaneous wr_ev and vb_ev:
  - Active receives the pre-write shadow.
  - The CPU write overrides the auto-step for the written byte field only.
  - Other fields of that layer still auto-step.
- COMMIT:
  - Pulses high for exactly 1 cycle on the edge after vb_ev.
  - Pulses even if every layer is frozen.
- FRAME increments with each COMMIT and wraps 0xFFFF -> 0x0000.
- RST, synchronous, on a clock edge with RST = 1:
  - All shadow, active, step and CTRL registers = 0.
  - DOUT = 0x00, COMMIT = 0, FRAME = 0.
  - Edge registers: LATCH_q = 0, nVBLANK_q = 1, so no spurious events on release.
  - RST asserted mid-frame discards pending shadow writes. The first commit occurs at the next full VBLANK falling edge after release.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Reset, then write layer 0 reg0 = 0x34 and reg1 = 0x01, no VBLANK -> HSCROLL[8:0] stays 0. After the next nVBLANK fall -> HSCROLL[8:0] = 0x134, COMMIT pulses 1 cycle, FRAME = 1.
2. Layer 2: HSTEP = 0x01, CTRL = 0x01, HSCROLL = 0x1FF. Run 3 frames -> active H across commits is 0x1FF, 0x000, 0x001 (wrap at 9 bits). Other layers stay 0.
3. Layer 1: VSTEP = 0xFE (-2), CTRL = 0x02, VSCROLL = 0x01. Two commits -> active V = 0x01, then 0xFF.
4. Write reg0 = 0x55 on the same cycle as vb_ev, with shadow 0x10 and auto-step +1 -> active = 0x010. Next commit -> active low byte = 0x55, high bits stepped.
5. Layer 3 CTRL = 0x04 (FREEZE), then write HSCROLL = 0x0AA -> active unchanged over 2 frames and COMMIT still pulses. Clear FREEZE -> 0x0AA appears at the next commit.
6. CA = {3'd5, 3'd0} write with LAYERS = 4 -> no state change, read returns 0x00. Assert RST mid-frame after a pending write -> all outputs 0, no COMMIT on release.
